// File: rtl/pe_pkg.sv
// Shared types, widths and saturating arithmetic for the pe_mac datapath.
package pe_pkg;

  // Default operand width and lane count of the processing element.
  localparam int PE_DATA_WIDTH = 8;
  localparam int PE_LANES      = 4;

  // Width of one lane product and of the summed lane products.
  localparam int PROD_WIDTH = 2 * PE_DATA_WIDTH;
  localparam int SUM_WIDTH  = PROD_WIDTH + $clog2(PE_LANES);

  // Internal width used for the saturating add; accumulators up to 62 bits fit.
  localparam int PE_CALC_WIDTH = 64;

  // Packet framing state: waiting for a packet, or in the middle of one.
  typedef enum logic {PE_IDLE, PE_ACCUM} pe_state_t;

  // Result of a saturating add: clamp flag plus the (possibly clamped) value.
  typedef struct packed {
    logic                     sat;
    logic [PE_CALC_WIDTH-1:0] value;
  } pe_sat_t;

  // Adds two operands already extended to PE_CALC_WIDTH according to the mode,
  // then clamps into the signed or unsigned range of an acc_width-bit register.
  function automatic pe_sat_t sat_add(input logic [PE_CALC_WIDTH-1:0] acc,
                                      input logic [PE_CALC_WIDTH-1:0] sum,
                                      input logic                     signed_mode,
                                      input int                       acc_width);
    pe_sat_t                          res;
    logic signed [PE_CALC_WIDTH-1:0]  total;
    logic signed [PE_CALC_WIDTH-1:0]  s_max;
    logic signed [PE_CALC_WIDTH-1:0]  s_min;
    logic        [PE_CALC_WIDTH-1:0]  u_max;
    total     = $signed(acc + sum);
    s_max     = (64'sd1 <<< (acc_width - 1)) - 64'sd1;
    s_min     = -(64'sd1 <<< (acc_width - 1));
    u_max     = (64'd1 << acc_width) - 64'd1;
    res.sat   = 1'b0;
    res.value = total;
    if (signed_mode) begin
      if (total > s_max) begin
        res.sat   = 1'b1;
        res.value = s_max;
      end else if (total < s_min) begin
        res.sat   = 1'b1;
        res.value = s_min;
      end
    end else begin
      if ($unsigned(total) > u_max) begin
        res.sat   = 1'b1;
        res.value = u_max;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_mul_lane.sv
// One multiplier lane: registers w*x in signed or unsigned mode, holding when en is low.
module pe_mul_lane
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      signed_mode,
  input  logic [DATA_WIDTH-1:0]     w,
  input  logic [DATA_WIDTH-1:0]     x,
  output logic [2*DATA_WIDTH-1:0]   prod
);

  // One extra bit lets a single signed multiplier cover both modes: the top bit
  // copies the sign in signed mode and is zero in unsigned mode.
  logic signed [DATA_WIDTH:0]     w_ext;
  logic signed [DATA_WIDTH:0]     x_ext;
  logic signed [2*DATA_WIDTH-1:0] full;

  assign w_ext = {signed_mode & w[DATA_WIDTH-1], w};
  assign x_ext = {signed_mode & x[DATA_WIDTH-1], x};
  assign full  = (2*DATA_WIDTH)'(w_ext) * (2*DATA_WIDTH)'(x_ext);

  // Product register; holds its value while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
    end else if (en) begin
      prod <= full;
    end
  end

endmodule

// File: rtl/pe_mac.sv
// Multi-lane multiply-accumulate element: per-lane products, lane reduction,
// saturating packet accumulation and a single result register with valid/ready.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int LANES      = PE_LANES,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]  in_w,
  input  logic [LANES*DATA_WIDTH-1:0]  in_x,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic                         in_signed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_acc,
  output logic                         out_sat
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW + $clog2(LANES);
  localparam int CW = PE_CALC_WIDTH;

  pe_state_t              state_q;
  pe_state_t              state_d;
  logic                   advance;
  logic                   accept;
  logic                   eff_first;
  logic                   beat_signed;
  logic                   mode_q;

  logic                   s1_valid;
  logic                   s1_first;
  logic                   s1_last;
  logic                   s1_signed;
  logic [LANES*PW-1:0]    s1_prod;

  logic signed [PW:0]     prod_ext;
  logic [SW-1:0]          lane_sum;

  logic [ACC_WIDTH-1:0]   acc_q;
  logic                   sat_q;
  logic signed [ACC_WIDTH:0] acc_sx;
  logic signed [SW:0]     sum_sx;
  logic [CW-1:0]          acc_base;
  logic [CW-1:0]          sum_ext;
  pe_sat_t                acc_next;
  logic                   sat_next;
  logic [CW-ACC_WIDTH-1:0] acc_hi_unused;

  // The whole pipeline moves only when the result register can take a new value.
  assign advance       = !(out_valid && !out_ready);
  assign in_ready      = advance;
  assign accept        = in_valid && advance;
  assign acc_hi_unused = acc_next.value[CW-1:ACC_WIDTH];

  // Packet state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A last beat closes the packet; any other accepted beat leaves one open.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = in_last ? PE_IDLE : PE_ACCUM;
    end
  end

  // A beat opens a packet when flagged or when no packet is open; mode comes from that beat.
  always_comb begin
    eff_first   = in_first || (state_q == PE_IDLE);
    beat_signed = eff_first ? in_signed : mode_q;
  end

  // Remember the packet mode so later beats ignore their in_signed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (accept && eff_first) begin
      mode_q <= in_signed;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_mul_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (advance),
      .signed_mode (beat_signed),
      .w           (in_w[i*DATA_WIDTH +: DATA_WIDTH]),
      .x           (in_x[i*DATA_WIDTH +: DATA_WIDTH]),
      .prod        (s1_prod[i*PW +: PW])
    );
  end

  // Stage-1 tags travel alongside the registered products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_signed <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_first  <= eff_first;
      s1_last   <= in_last;
      s1_signed <= beat_signed;
    end
  end

  // Reduce the lane products, each extended according to the packet mode.
  always_comb begin
    prod_ext = '0;
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_ext = {s1_signed & s1_prod[i*PW + PW - 1], s1_prod[i*PW +: PW]};
      lane_sum = lane_sum + SW'(prod_ext);
    end
  end

  // Next accumulator value: restart from zero on a first beat, otherwise add and clamp.
  always_comb begin
    acc_sx   = {s1_signed & acc_q[ACC_WIDTH-1], acc_q};
    sum_sx   = {s1_signed & lane_sum[SW-1], lane_sum};
    acc_base = s1_first ? '0 : CW'(acc_sx);
    sum_ext  = CW'(sum_sx);
    acc_next = sat_add(acc_base, sum_ext, s1_signed, ACC_WIDTH);
    sat_next = (s1_first ? 1'b0 : sat_q) | acc_next.sat;
  end

  // Accumulator and sticky saturation flag advance once per valid stage-1 beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (advance && s1_valid) begin
      acc_q <= acc_next.value[ACC_WIDTH-1:0];
      sat_q <= sat_next;
    end
  end

  // Result register: loads on a last beat, clears when consumed, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
    end else if (advance && s1_valid && s1_last) begin
      out_valid <= 1'b1;
      out_acc   <= acc_next.value[ACC_WIDTH-1:0];
      out_sat   <= sat_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_mac.sv
// Testbench for pe_mac: a wide (32-bit) and a narrow (18-bit) accumulator instance
// share the stimulus and are checked every cycle against a packet-level model.
module tb_pe_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_first, in_last, in_signed, out_ready;
  logic [31:0] in_w, in_x;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, out_sat0, out_sat1;
  logic [31:0] out_acc0;
  logic [17:0] out_acc1;

  int errors = 0;
  int checks = 0;

  // Model state per instance: visible result, one result in flight, open packet.
  bit     mv[2];
  longint m_acc[2];
  bit     m_sat[2];
  bit     fl_v[2];
  longint fl_acc[2];
  bit     fl_sat[2];
  bit     in_pkt[2];
  bit     pmode[2];
  longint pacc[2];
  bit     psat[2];
  longint res0_acc[$];
  longint res1_acc[$];
  bit     res0_sat[$];
  bit     res1_sat[$];
  int     got0 = 0;
  int     got1 = 0;

  pe_mac #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_w(in_w), .in_x(in_x), .in_first(in_first), .in_last(in_last),
    .in_signed(in_signed), .out_valid(out_valid0), .out_ready(out_ready),
    .out_acc(out_acc0), .out_sat(out_sat0)
  );

  // Deliberately narrow accumulator so a few beats reach the clamp.
  pe_mac #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(18)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_w(in_w), .in_x(in_x), .in_first(in_first), .in_last(in_last),
    .in_signed(in_signed), .out_valid(out_valid1), .out_ready(out_ready),
    .out_acc(out_acc1), .out_sat(out_sat1)
  );

  always #5 clk = ~clk;

  function automatic int acc_w(input int i);
    return (i == 0) ? 32 : 18;
  endfunction

  function automatic logic [31:0] rep(input logic [7:0] b);
    return {4{b}};
  endfunction

  // Dot product of one beat in plain integer arithmetic.
  function automatic longint beat_sum(input logic [31:0] w, input logic [31:0] x, input bit s);
    longint     t = 0;
    longint     a, b;
    logic [7:0] wb, xb;
    for (int l = 0; l < 4; l++) begin
      wb = w[l*8 +: 8];
      xb = x[l*8 +: 8];
      a  = s ? longint'($signed(wb)) : longint'(wb);
      b  = s ? longint'($signed(xb)) : longint'(xb);
      t  = t + a * b;
    end
    return t;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; m_acc[i] = 0; m_sat[i] = 0;
      fl_v[i] = 0; fl_acc[i] = 0; fl_sat[i] = 0;
      in_pkt[i] = 0; pmode[i] = 0; pacc[i] = 0; psat[i] = 0;
    end
  endtask

  // One clock edge of the model: a result shows up two accepted-cycles after its last beat,
  // and nothing moves while a shown result waits for out_ready.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit     stall, first;
      longint total, smax, smin, umax;
      stall = mv[i] && !out_ready;
      if (!stall) begin
        if (fl_v[i]) begin
          mv[i] = 1; m_acc[i] = fl_acc[i]; m_sat[i] = fl_sat[i];
          if (i == 0) begin res0_acc.push_back(fl_acc[i]); res0_sat.push_back(fl_sat[i]); end
          else        begin res1_acc.push_back(fl_acc[i]); res1_sat.push_back(fl_sat[i]); end
        end else if (out_ready) begin
          mv[i] = 0;
        end
        fl_v[i] = 0;
        if (in_valid) begin
          first = in_first || !in_pkt[i];
          if (first) begin
            pmode[i] = in_signed; pacc[i] = 0; psat[i] = 0;
          end
          total = pacc[i] + beat_sum(in_w, in_x, pmode[i]);
          smax  = (longint'(1) << (acc_w(i) - 1)) - 1;
          smin  = -(longint'(1) << (acc_w(i) - 1));
          umax  = (longint'(1) << acc_w(i)) - 1;
          if (pmode[i] && total > smax)       begin total = smax; psat[i] = 1; end
          else if (pmode[i] && total < smin)  begin total = smin; psat[i] = 1; end
          else if (!pmode[i] && total > umax) begin total = umax; psat[i] = 1; end
          pacc[i] = total;
          if (in_last) begin
            fl_v[i] = 1; fl_acc[i] = pacc[i]; fl_sat[i] = psat[i]; in_pkt[i] = 0;
          end else begin
            in_pkt[i] = 1;
          end
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else        model_step();
    end
  end

  // Every cycle, compare both instances with the model.
  task automatic compare_outputs();
    for (int i = 0; i < 2; i++) begin
      bit          rdy, vld, st, exp_rdy;
      logic [63:0] act_acc, exp_acc, mask;
      if (i == 0) begin rdy = in_ready0; vld = out_valid0; st = out_sat0; act_acc = 64'(out_acc0); end
      else        begin rdy = in_ready1; vld = out_valid1; st = out_sat1; act_acc = 64'(out_acc1); end
      mask    = (64'd1 << acc_w(i)) - 64'd1;
      exp_acc = 64'(m_acc[i]) & mask;
      exp_rdy = !(mv[i] && !out_ready);
      checks++;
      if (rdy != exp_rdy) begin
        errors++;
        $display("[TB] FAIL dut%0d in_ready @%0t: got %0b expected %0b", i, $time, rdy, exp_rdy);
      end
      checks++;
      if (vld != mv[i]) begin
        errors++;
        $display("[TB] FAIL dut%0d out_valid @%0t: got %0b expected %0b", i, $time, vld, mv[i]);
      end
      if (mv[i]) begin
        checks++;
        if (act_acc != exp_acc) begin
          errors++;
          $display("[TB] FAIL dut%0d out_acc @%0t: got %0h expected %0h", i, $time, act_acc, exp_acc);
        end
        checks++;
        if (st != m_sat[i]) begin
          errors++;
          $display("[TB] FAIL dut%0d out_sat @%0t: got %0b expected %0b", i, $time, st, m_sat[i]);
        end
      end
      if (vld && out_ready) begin
        if (i == 0) got0++; else got1++;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_outputs();
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Present one beat (called just after a rising edge) and return once it is accepted.
  task automatic applyStimulus(input logic f, input logic l, input logic s,
                               input logic [31:0] w, input logic [31:0] x);
    int waited = 0;
    in_valid = 1'b1; in_first = f; in_last = l; in_signed = s; in_w = w; in_x = x;
    #1;
    while ((mv[0] && !out_ready) && waited < 50) begin
      @(posedge clk); #2;
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout @%0t: got no acceptance expected within 50 cycles", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected before 200000");
    $fatal(1, "[TB] watchdog");
  end

  longint exp0_acc[14] = '{70, 512, 130560, 72, 72, 391680, 8, 8, 16, 36, 193548, 4, -193548, 4};
  longint exp1_acc[14] = '{70, 512, 130560, 72, 72, 262143, 8, 8, 16, 36, 131071, 4, -131072, 4};
  bit     exp1_sat[14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0};

  initial begin
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_signed = 1'b0;
    in_w = '0; in_x = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset in_ready0", longint'(in_ready0), 1);
    checkOutput("reset in_ready1", longint'(in_ready1), 1);
    checkOutput("reset out_valid0", longint'(out_valid0), 0);
    checkOutput("reset out_acc0", longint'(out_acc0), 0);
    checkOutput("reset out_sat1", longint'(out_sat1), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // One-beat unsigned packet, then signed/unsigned mode pair back to back.
    applyStimulus(1, 1, 0, 32'h04030201, 32'h08070605);
    idle(3);
    applyStimulus(1, 1, 1, rep(8'hFF), rep(8'h80));
    applyStimulus(1, 1, 0, rep(8'hFF), rep(8'h80));
    idle(3);

    // Three-beat packets; in_signed on later beats must be ignored.
    applyStimulus(1, 0, 0, rep(8'd2), rep(8'd3));
    applyStimulus(0, 0, 0, rep(8'd2), rep(8'd3));
    applyStimulus(0, 1, 0, rep(8'd2), rep(8'd3));
    idle(3);
    applyStimulus(1, 0, 0, rep(8'd2), rep(8'd3));
    applyStimulus(0, 0, 1, rep(8'd2), rep(8'd3));
    applyStimulus(0, 1, 1, rep(8'd2), rep(8'd3));
    idle(3);
    applyStimulus(1, 0, 0, rep(8'hFF), rep(8'h80));
    applyStimulus(0, 0, 1, rep(8'hFF), rep(8'h80));
    applyStimulus(0, 1, 1, rep(8'hFF), rep(8'h80));
    idle(3);

    // Packet opened without in_first, then a mid-packet restart.
    applyStimulus(0, 0, 0, rep(8'd1), rep(8'd1));
    applyStimulus(0, 1, 0, rep(8'd1), rep(8'd1));
    idle(3);
    applyStimulus(1, 0, 0, rep(8'd5), rep(8'd5));
    applyStimulus(1, 0, 0, rep(8'd1), rep(8'd1));
    applyStimulus(0, 1, 0, rep(8'd1), rep(8'd1));
    idle(3);

    // Backpressure: result held while a second packet tries to stream in.
    out_ready = 1'b0;
    applyStimulus(1, 1, 0, rep(8'd2), rep(8'd2));
    fork
      begin
        applyStimulus(1, 0, 0, rep(8'd1), rep(8'd3));
        applyStimulus(0, 0, 0, rep(8'd1), rep(8'd3));
        applyStimulus(0, 1, 0, rep(8'd1), rep(8'd3));
      end
      begin
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(4);

    // Signed saturation (positive), clean packet, signed saturation (negative).
    applyStimulus(1, 0, 1, rep(8'd127), rep(8'd127));
    applyStimulus(0, 0, 1, rep(8'd127), rep(8'd127));
    applyStimulus(0, 1, 1, rep(8'd127), rep(8'd127));
    applyStimulus(1, 1, 1, rep(8'd1), rep(8'd1));
    applyStimulus(1, 0, 1, rep(8'd127), rep(8'h81));
    applyStimulus(0, 0, 1, rep(8'd127), rep(8'h81));
    applyStimulus(0, 1, 1, rep(8'd127), rep(8'h81));
    idle(4);

    // Reset after two beats of a three-beat packet.
    applyStimulus(1, 0, 0, rep(8'd3), rep(8'd3));
    applyStimulus(0, 0, 0, rep(8'd3), rep(8'd3));
    rst_n = 1'b0;
    #2;
    checkOutput("midreset out_valid0", longint'(out_valid0), 0);
    checkOutput("midreset out_acc0", longint'(out_acc0), 0);
    checkOutput("midreset out_acc1", longint'(out_acc1), 0);
    checkOutput("midreset out_sat1", longint'(out_sat1), 0);
    idle(2);
    rst_n = 1'b1;
    applyStimulus(1, 1, 0, rep(8'd1), rep(8'd1));
    idle(4);

    // Pin the model against hand-computed results, and the DUTs' handshake counts.
    checkOutput("model0 result count", longint'(res0_acc.size()), 14);
    checkOutput("model1 result count", longint'(res1_acc.size()), 14);
    for (int k = 0; k < 14 && k < res0_acc.size(); k++) begin
      checkOutput($sformatf("model0 acc[%0d]", k), res0_acc[k], exp0_acc[k]);
      checkOutput($sformatf("model0 sat[%0d]", k), longint'(res0_sat[k]), 0);
    end
    for (int k = 0; k < 14 && k < res1_acc.size(); k++) begin
      checkOutput($sformatf("model1 acc[%0d]", k), res1_acc[k], exp1_acc[k]);
      checkOutput($sformatf("model1 sat[%0d]", k), longint'(res1_sat[k]), longint'(exp1_sat[k]));
    end
    checkOutput("dut0 results consumed", longint'(got0), 14);
    checkOutput("dut1 results consumed", longint'(got1), 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
